// File: rtl/iomem_bridge_pkg.sv
// iomem_bridge_pkg
//   Shared constants for the byte-stream-to-iomem bridge: command opcodes,
//   response codes, response lengths and the bridge FSM state encoding.
package iomem_bridge_pkg;

   localparam logic [7:0] OP_READ     = 8'h52;   // 'R'
   localparam logic [7:0] OP_WRITE    = 8'h57;   // 'W'

   localparam logic [7:0] RSP_OK      = 8'h4B;   // 'K'
   localparam logic [7:0] RSP_TIMEOUT = 8'h54;   // 'T'
   localparam logic [7:0] RSP_BADOP   = 8'h3F;   // '?'

   // Response lengths in bytes: a bare status code, or 'K' plus 4 data bytes.
   localparam logic [2:0] RESP_LEN_SHORT = 3'd1;
   localparam logic [2:0] RESP_LEN_LONG  = 3'd5;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      STRB,
      DATA,
      BUS,
      RESP
   } state_e;

endpackage

// File: rtl/iomem_resp_shifter.sv
// iomem_resp_shifter
//   Holds a response frame of up to 5 bytes and streams it out MSB byte first
//   over a valid/ready byte interface. Handles tx backpressure on its own so
//   the bridge FSM only has to load it and wait for done.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   load_i           load load_data_i/load_len_i (only used while not sending)
//   load_data_i[39:0] frame, first byte in bits [39:32]
//   load_len_i[2:0]  number of bytes to send (1 or 5)
//   tx_ready_i       sink accepts the current byte
//   tx_valid_o       byte available
//   tx_data_o[7:0]   current byte
//   done_o           last byte is being accepted this cycle
module iomem_resp_shifter (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_i,
   input  logic [39:0] load_data_i,
   input  logic [2:0]  load_len_i,
   input  logic        tx_ready_i,
   output logic        tx_valid_o,
   output logic [7:0]  tx_data_o,
   output logic        done_o
);

   logic [39:0] shreg_q;
   logic [2:0]  remain_q;
   logic        tx_valid_q;
   logic        tx_fire;

   assign tx_fire    = tx_valid_q && tx_ready_i;
   assign done_o     = tx_fire && (remain_q == 3'd1);
   assign tx_valid_o = tx_valid_q;
   assign tx_data_o  = shreg_q[39:32];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg_q    <= '0;
         remain_q   <= '0;
         tx_valid_q <= 1'b0;
      end else if (load_i) begin
         shreg_q    <= load_data_i;
         remain_q   <= load_len_i;
         tx_valid_q <= (load_len_i != 3'd0);
      end else if (tx_fire) begin
         // Zeros shift in behind the frame, so tx_data reads 0 once drained.
         shreg_q  <= {shreg_q[31:0], 8'h00};
         remain_q <= remain_q - 3'd1;
         if (remain_q == 3'd1) begin
            tx_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/iomem_cmd_master.sv
// iomem_cmd_master
//   Byte-stream-to-iomem bridge (bus initiator). Parses 'R'/'W' command
//   frames from an rx byte stream, runs one iomem transaction with a
//   TIMEOUT_CYCLES watchdog, and returns a framed response on the tx stream.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   rx_valid/rx_data/rx_ready  command byte input (valid/ready)
//   tx_valid/tx_data/tx_ready  response byte output (valid/ready)
//   iomem_valid/iomem_ready    transaction request / completion pulse
//   iomem_wstrb/addr/wdata     request fields, held while iomem_valid=1
//   iomem_rdata                read data, sampled when iomem_ready=1
//   busy                       high whenever the FSM is not in IDLE
module iomem_cmd_master #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        iomem_valid,
   input  logic        iomem_ready,
   output logic [3:0]  iomem_wstrb,
   output logic [31:0] iomem_addr,
   output logic [31:0] iomem_wdata,
   input  logic [31:0] iomem_rdata,
   output logic        busy
);

   import iomem_bridge_pkg::*;

   // Count value at which the current BUS cycle is the last one allowed.
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_e      state_q, state_d;
   logic        is_write_q, is_write_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [15:0] tmo_cnt_q, tmo_cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic        valid_q, valid_d;
   logic        rx_ready_q, rx_ready_d;

   logic        rx_fire;
   logic        ld;
   logic [39:0] ld_data;
   logic [2:0]  ld_len;
   logic        tx_done;

   assign rx_fire     = rx_valid && rx_ready_q;
   assign rx_ready    = rx_ready_q;
   assign iomem_valid = valid_q;
   assign iomem_addr  = addr_q;
   assign iomem_wdata = wdata_q;
   assign iomem_wstrb = wstrb_q;
   assign busy        = (state_q != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         is_write_q <= 1'b0;
         byte_cnt_q <= '0;
         tmo_cnt_q  <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         valid_q    <= 1'b0;
         rx_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         is_write_q <= is_write_d;
         byte_cnt_q <= byte_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         valid_q    <= valid_d;
         rx_ready_q <= rx_ready_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      is_write_d = is_write_q;
      byte_cnt_d = byte_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      valid_d    = valid_q;
      ld         = 1'b0;
      ld_data    = '0;
      ld_len     = RESP_LEN_SHORT;

      case (state_q)
         IDLE: begin
            if (rx_fire) begin
               if (rx_data == OP_READ || rx_data == OP_WRITE) begin
                  is_write_d = (rx_data == OP_WRITE);
                  byte_cnt_d = '0;
                  state_d    = ADDR;
               end else begin
                  ld      = 1'b1;
                  ld_data = {RSP_BADOP, 32'h0};
                  state_d = RESP;
               end
            end
         end
         ADDR: begin
            if (rx_fire) begin
               addr_d     = {addr_q[23:0], rx_data};
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  if (is_write_q) begin
                     state_d = STRB;
                  end else begin
                     wstrb_d   = 4'h0;
                     valid_d   = 1'b1;
                     tmo_cnt_d = '0;
                     state_d   = BUS;
                  end
               end
            end
         end
         STRB: begin
            if (rx_fire) begin
               wstrb_d = rx_data[3:0];
               state_d = DATA;
            end
         end
         DATA: begin
            if (rx_fire) begin
               wdata_d    = {wdata_q[23:0], rx_data};
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  valid_d   = 1'b1;
                  tmo_cnt_d = '0;
                  state_d   = BUS;
               end
            end
         end
         BUS: begin
            // Completion takes priority over an expiring watchdog.
            if (iomem_ready) begin
               valid_d = 1'b0;
               ld      = 1'b1;
               state_d = RESP;
               // The reply follows the opcode, so a 'W' with S=0 still gets
               // a bare 'K' even though it went out as a read.
               if (is_write_q) begin
                  ld_data = {RSP_OK, 32'h0};
               end else begin
                  ld_data = {RSP_OK, iomem_rdata};
                  ld_len  = RESP_LEN_LONG;
               end
            end else if (tmo_cnt_q == TMO_LAST) begin
               valid_d = 1'b0;
               ld      = 1'b1;
               ld_data = {RSP_TIMEOUT, 32'h0};
               state_d = RESP;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
         end
         RESP: begin
            if (tx_done) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      rx_ready_d = (state_d == IDLE) || (state_d == ADDR) ||
                   (state_d == STRB) || (state_d == DATA);
   end

   iomem_resp_shifter u_resp (
      .clk         (clk),
      .reset       (reset),
      .load_i      (ld),
      .load_data_i (ld_data),
      .load_len_i  (ld_len),
      .tx_ready_i  (tx_ready),
      .tx_valid_o  (tx_valid),
      .tx_data_o   (tx_data),
      .done_o      (tx_done)
   );

endmodule

// File: tb/tb_iomem_cmd_master.sv
module tb_iomem_cmd_master;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;
   logic        busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      bit          chk_wdata;
   } bus_exp_t;

   bus_exp_t    bus_q[$];
   int          len_q[$];
   logic [7:0]  tx_q[$];

   // responder configuration
   int          resp_delay = 0;
   bit          resp_never = 1'b0;
   logic [31:0] resp_rdata = '0;
   int          vcnt = 0;

   // monitor state
   int          tx_count = 0;
   int          rises = 0;
   int          vlen = 0;
   logic        val_prev = 1'b0, rdy_prev = 1'b0;
   logic        txv_prev = 1'b0, txr_prev = 1'b0;
   logic [7:0]  txd_prev = '0;
   logic [31:0] cap_addr, cap_wdata;
   logic [3:0]  cap_wstrb;

   iomem_cmd_master #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk         (clk),
      .reset       (reset),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .rx_ready    (rx_ready),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_ready    (tx_ready),
      .iomem_valid (iomem_valid),
      .iomem_ready (iomem_ready),
      .iomem_wstrb (iomem_wstrb),
      .iomem_addr  (iomem_addr),
      .iomem_wdata (iomem_wdata),
      .iomem_rdata (iomem_rdata),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Responder: ready pulses in valid cycle resp_delay+1 unless resp_never.
   always @(posedge clk) begin
      #1;
      if (iomem_valid) vcnt++;
      else vcnt = 0;
      if (iomem_valid && !resp_never && vcnt == resp_delay + 1) begin
         iomem_ready = 1'b1;
         iomem_rdata = resp_rdata;
      end else begin
         iomem_ready = 1'b0;
         iomem_rdata = $urandom;
      end
   end

   // Monitor: samples on the falling edge, compares against the scoreboard.
   always @(negedge clk) begin
      if (!reset) begin
         if (tx_valid && tx_ready) begin
            tx_count++;
            if (tx_q.size() > 0) chk("tx_byte", tx_data, tx_q.pop_front());
            else chk("tx_extra", tx_q.size(), 1);
         end
         if (txv_prev && !txr_prev) chk("tx_hold", {tx_valid, tx_data}, {1'b1, txd_prev});
         if (rdy_prev) chk("lat_tx", tx_valid, 1);
         if (iomem_valid && !val_prev) begin
            rises++;
            vlen = 1;
            cap_addr = iomem_addr;
            cap_wstrb = iomem_wstrb;
            cap_wdata = iomem_wdata;
            if (bus_q.size() > 0) begin
               bus_exp_t e;
               e = bus_q.pop_front();
               chk("bus_addr", iomem_addr, e.addr);
               chk("bus_wstrb", iomem_wstrb, e.wstrb);
               if (e.chk_wdata) chk("bus_wdata", iomem_wdata, e.wdata);
            end else begin
               chk("bus_extra", bus_q.size(), 1);
            end
         end else if (iomem_valid) begin
            vlen++;
            chk("hold_req", {cap_addr, cap_wstrb, cap_wdata} == {iomem_addr, iomem_wstrb, iomem_wdata}, 1);
         end
         if (!iomem_valid && val_prev) begin
            if (len_q.size() > 0) chk("valid_len", vlen, len_q.pop_front());
            else chk("len_extra", len_q.size(), 1);
         end
      end
      val_prev = iomem_valid;
      rdy_prev = iomem_valid && iomem_ready;
      txv_prev = tx_valid;
      txr_prev = tx_ready;
      txd_prev = tx_data;
   end

   task automatic send_byte(input logic [7:0] b);
      bit ok = 1'b0;
      rx_valid = 1'b1;
      rx_data  = b;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (rx_ready) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
            break;
         end
      end
      chk("rx_accept", ok, 1);
      rx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #1;
         if (!busy && tx_q.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      chk("idle_wait", done, 1);
   endtask

   // Push expected bus request, valid length and response for one command.
   task automatic expect_txn(input logic [31:0] addr, input logic [3:0] ws,
                             input logic [31:0] wd, input bit is_wr,
                             input int delay, input bit never, input logic [31:0] rd);
      bus_exp_t e;
      bit tmo;
      tmo = never || (delay + 1 > TMO);
      e.addr = addr; e.wstrb = ws; e.wdata = wd; e.chk_wdata = is_wr;
      bus_q.push_back(e);
      len_q.push_back(tmo ? TMO : delay + 1);
      if (tmo) tx_q.push_back(8'h54);
      else begin
         tx_q.push_back(8'h4B);
         if (!is_wr) begin
            tx_q.push_back(rd[31:24]); tx_q.push_back(rd[23:16]);
            tx_q.push_back(rd[15:8]);  tx_q.push_back(rd[7:0]);
         end
      end
      resp_delay = delay; resp_never = never; resp_rdata = rd;
   endtask

   task automatic send_read(input logic [31:0] addr);
      send_byte(8'h52);
      for (int i = 3; i >= 0; i--) send_byte(addr[i*8 +: 8]);
      chk("lat_valid", iomem_valid, 1);
   endtask

   task automatic send_write(input logic [31:0] addr, input logic [7:0] s, input logic [31:0] d);
      send_byte(8'h57);
      for (int i = 3; i >= 0; i--) send_byte(addr[i*8 +: 8]);
      send_byte(s);
      for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
      chk("lat_valid", iomem_valid, 1);
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [31:0] rd, input int delay, input bit never);
      expect_txn(addr, 4'h0, 32'h0, 1'b0, delay, never, rd);
      send_read(addr);
      wait_idle();
      $display("txn read  addr=%08h rdata=%08h delay=%0d never=%0d", addr, rd, delay, never);
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [7:0] s, input logic [31:0] d, input int delay);
      expect_txn(addr, s[3:0], d, 1'b1, delay, 1'b0, 32'h0);
      send_write(addr, s, d);
      wait_idle();
      $display("txn write addr=%08h strb=%02h wdata=%08h delay=%0d", addr, s, d, delay);
   endtask

   initial begin
      int r0;
      int c0;
      reset = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b1;
      iomem_ready = 1'b0; iomem_rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rx_ready", rx_ready, 0);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_valid", iomem_valid, 0);
      chk("rst_wstrb", iomem_wstrb, 0);
      chk("rst_addr", iomem_addr, 0);
      chk("rst_wdata", iomem_wdata, 0);
      chk("rst_busy", busy, 0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_rx_ready", rx_ready, 1);

      do_read(32'h03000000, 32'hDEADBEEF, 2, 1'b0);
      do_write(32'h06000000, 8'h03, 32'h00001234, 1);
      do_read(32'h01000020, 32'h11223344, 0, 1'b1);      // watchdog expiry
      do_read(32'h00000010, 32'h55667788, 0, 1'b0);      // next command after timeout
      do_read(32'h0000ABCD, 32'h0BADF00D, TMO - 1, 1'b0); // ready on expiry cycle
      do_read(32'h0000ABCE, 32'h12345678, TMO, 1'b0);     // ready one cycle too late
      do_write(32'h40000000, 8'hF0, 32'hFFEE0001, 2);     // S=0: read on bus, 'K' reply

      // Unknown opcode: '?' only, no bus request.
      r0 = rises;
      tx_q.push_back(8'h3F);
      send_byte(8'h41);
      wait_idle();
      chk("badop_no_bus", rises, r0);
      chk("badop_rx_ready", rx_ready, 1);
      $display("txn badop byte=41");

      // Backpressure in the middle of a read response.
      c0 = tx_count;
      expect_txn(32'h0A0B0C0D, 4'h0, 32'h0, 1'b0, 1, 1'b0, 32'hCAFEF00D);
      send_read(32'h0A0B0C0D);
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (tx_count >= c0 + 2) break;
      end
      tx_ready = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      tx_ready = 1'b1;
      wait_idle();
      chk("bp_bytes", tx_count - c0, 5);
      $display("txn read  addr=0a0b0c0d rdata=cafef00d with tx backpressure");

      // Asynchronous reset while a request is outstanding.
      expect_txn(32'h0C000000, 4'h0, 32'h0, 1'b0, 0, 1'b1, 32'h0);
      send_read(32'h0C000000);
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_valid", iomem_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_tx_valid", tx_valid, 0);
      tx_q.delete();
      len_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("post_rst_busy", busy, 0);
      @(posedge clk);
      #1;
      chk("post_rst_rx_ready", rx_ready, 1);
      $display("txn reset during bus request");
      do_write(32'h20000004, 8'h0F, 32'hA5A5A5A5, 3);

      repeat (3) @(posedge clk);
      chk("end_tx_q", tx_q.size(), 0);
      chk("end_bus_q", bus_q.size(), 0);
      chk("end_len_q", len_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
